// File: rtl/pipe_stage_buffer.sv
// -----------------------------------------------------------------------------
// pipe_stage_buffer
//
// Elastic pipeline register placed between two pipeline stages. It holds up to
// DEPTH payload entries (normally one packed stage struct each) in strict FIFO
// order. It uses valid/ready handshaking on both sides, so a downstream stall
// turns into upstream backpressure instead of a hand-wired enable.
//
// DEPTH = 1 behaves as a plain stage register. Because in_ready is registered,
// it moves at most one entry every two cycles. DEPTH >= 2 sustains one entry
// per cycle.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous, active-high; clears occupancy and pointers
//   flush      synchronous discard of every held entry (branch/exception squash)
//   in_valid   upstream presents in_data
//   in_ready   buffer can accept; decoded from the occupancy register only,
//              so there is no combinational path from out_ready
//   in_data    upstream payload, WIDTH bits
//   out_valid  out_data holds the oldest entry
//   out_ready  downstream accepts this cycle
//   out_data   oldest entry; forced to zero while out_valid is low
//   count      current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module pipe_stage_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    // A single-entry buffer still needs a 1-bit pointer so that the port
    // and array widths stay legal. That pointer simply never leaves 0.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Payload storage. It is deliberately not reset: stale contents are
    // hidden because out_data is masked whenever the buffer is empty.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             push;
    logic             pop;

    // Pointers wrap explicitly at DEPTH-1, so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    always_comb begin
        in_ready    = (count_reg < FULL_CNT);
        out_valid   = (count_reg != '0);
        out_data    = out_valid ? mem[rd_ptr_reg] : '0;
        count       = count_reg;

        // Flush has priority: a transfer offered in the same cycle as a
        // squash must neither land nor leave.
        push        = in_valid  & in_ready  & ~flush;
        pop         = out_valid & out_ready & ~flush;

        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;

        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) begin
                wr_ptr_next = ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_next = ptr_inc(rd_ptr_reg);
            end
            // A simultaneous push and pop leaves occupancy unchanged.
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    // Occupancy can never exceed the number of physical entries.
    a_count_range : assert property (
        @(posedge clock) disable iff (reset) count_reg <= FULL_CNT
    ) else $error("pipe_stage_buffer: occupancy above DEPTH");

    // While an offer is stalled, the upstream stage must keep its payload steady.
    a_in_data_hold : assert property (
        @(posedge clock) disable iff (reset)
        (in_valid && !in_ready) |=> (!in_valid || $stable(in_data))
    ) else $warning("pipe_stage_buffer: in_data changed while stalled");

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// -----------------------------------------------------------------------------
// Bench for pipe_stage_buffer. It builds three 8-bit instances:
//   inst 0: DEPTH=2, used for reset, streaming, backpressure and flush
//   inst 1: DEPTH=3, used for random-handshake ordering across pointer wraps
//   inst 2: DEPTH=1, used for half-rate continuous flow
// Each instance has a queue model. On every negedge, one compare process
// checks the outputs of all three instances against their models. Directed
// sequences add literal expectations that pin the model itself.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       flush     [3];
    logic       in_valid  [3];
    logic       out_ready [3];
    logic [7:0] in_data   [3];
    logic       out_valid [3];
    logic       in_ready  [3];
    logic [7:0] out_data  [3];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int D  = (gi == 0) ? 2 : ((gi == 1) ? 3 : 1);
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] cnt_l;

        pipe_stage_buffer #(.WIDTH(8), .DEPTH(D)) dut (
            .clock     (clk),
            .reset     (rst),
            .flush     (flush[gi]),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_data   (in_data[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .out_data  (out_data[gi]),
            .count     (cnt_l)
        );

        // Model: a plain queue with capacity D. It accepts an entry when it
        // has room, drops everything on flush, and shows its head.
        logic [7:0] q [$];
        logic       ev;
        logic [7:0] ed;
        logic [1:0] ec;
        logic       er;
        initial begin
            bit room, psh, pp;
            ev = 1'b0; ed = 8'h00; ec = 2'd0; er = 1'b1;
            forever begin
                @(posedge clk or posedge rst);
                if (rst) begin
                    q.delete();
                end else begin
                    room = (q.size() < D);
                    psh  = in_valid[gi] && room && !flush[gi];
                    pp   = (q.size() != 0) && out_ready[gi] && !flush[gi];
                    if (flush[gi]) begin
                        q.delete();
                    end else begin
                        if (pp)  void'(q.pop_front());
                        if (psh) q.push_back(in_data[gi]);
                    end
                end
                ec = 2'(q.size());
                ev = (q.size() != 0);
                ed = ev ? q[0] : 8'h00;
                er = (q.size() < D);
            end
        end
    end

    // Single compare process against the models.
    initial begin
        forever begin
            @(negedge clk);
            check("i0 out_valid", out_valid[0], g_dut[0].ev);
            check("i0 out_data",  out_data[0],  g_dut[0].ed);
            check("i0 count",     g_dut[0].cnt_l, g_dut[0].ec);
            check("i0 in_ready",  in_ready[0],  g_dut[0].er);
            check("i1 out_valid", out_valid[1], g_dut[1].ev);
            check("i1 out_data",  out_data[1],  g_dut[1].ed);
            check("i1 count",     g_dut[1].cnt_l, g_dut[1].ec);
            check("i1 in_ready",  in_ready[1],  g_dut[1].er);
            check("i2 out_valid", out_valid[2], g_dut[2].ev);
            check("i2 out_data",  out_data[2],  g_dut[2].ed);
            check("i2 count",     g_dut[2].cnt_l, g_dut[2].ec);
            check("i2 in_ready",  in_ready[2],  g_dut[2].er);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int sent, got, cyc, pops;
        bit will_push, will_pop;
        logic [7:0] rcv [20];
        logic [7:0] val;

        for (int i = 0; i < 3; i++) begin
            flush[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_data[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        check("reset count", g_dut[0].cnt_l, 0);
        check("reset in_ready", in_ready[0], 1);

        // T1: fill inst 0, then assert reset between clock edges.
        in_valid[0] = 1'b1; in_data[0] = 8'hA1; tick();
        in_data[0] = 8'hA2; tick();
        in_valid[0] = 1'b0; in_data[0] = 8'h00;
        check("t1 full count", g_dut[0].cnt_l, 2);
        check("t1 full in_ready", in_ready[0], 0);
        check("t1 head", out_data[0], 8'hA1);
        #1 rst = 1'b1;
        #1;
        check("t1 async out_valid", out_valid[0], 0);
        check("t1 async out_data", out_data[0], 0);
        check("t1 async count", g_dut[0].cnt_l, 0);
        check("t1 async in_ready", in_ready[0], 1);
        tick();
        rst = 1'b0;

        // T2: continuous stream of 1..8 with out_ready held high.
        out_ready[0] = 1'b1; in_valid[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_data[0] = 8'(k);
            tick();
            check("t2 stream data", out_data[0], 32'(k));
            check("t2 stream count", g_dut[0].cnt_l, 1);
        end
        in_valid[0] = 1'b0; tick();
        check("t2 drained", out_valid[0], 0);
        out_ready[0] = 1'b0;

        // T3: backpressure with A, B, C.
        in_valid[0] = 1'b1; in_data[0] = 8'h0A; tick();
        in_data[0] = 8'h0B; tick();
        in_data[0] = 8'h0C; tick();
        check("t3 full in_ready", in_ready[0], 0);
        check("t3 full count", g_dut[0].cnt_l, 2);
        check("t3 head A", out_data[0], 8'h0A);
        tick();
        check("t3 head stable", out_data[0], 8'h0A);
        out_ready[0] = 1'b1; tick();
        check("t3 second B", out_data[0], 8'h0B);
        check("t3 C held count", g_dut[0].cnt_l, 1);
        tick();
        check("t3 third C", out_data[0], 8'h0C);
        in_valid[0] = 1'b0; tick();
        check("t3 empty", out_valid[0], 0);
        out_ready[0] = 1'b0;

        // T5: flush while full, with a concurrent offer of 0x55.
        in_valid[0] = 1'b1; in_data[0] = 8'h11; tick();
        in_data[0] = 8'h22; tick();
        check("t5 full count", g_dut[0].cnt_l, 2);
        in_data[0] = 8'h55; flush[0] = 1'b1; tick();
        flush[0] = 1'b0; in_valid[0] = 1'b0; in_data[0] = 8'h00;
        check("t5 flushed count", g_dut[0].cnt_l, 0);
        check("t5 flushed valid", out_valid[0], 0);
        check("t5 flushed data", out_data[0], 0);
        repeat (3) begin
            tick();
            check("t5 no 0x55", out_valid[0], 0);
        end
        flush[0] = 1'b1; tick(); flush[0] = 1'b0;
        check("t5 empty flush count", g_dut[0].cnt_l, 0);
        in_valid[0] = 1'b1; in_data[0] = 8'h66; tick();
        in_valid[0] = 1'b0;
        check("t5 post-flush data", out_data[0], 8'h66);
        check("t5 post-flush count", g_dut[0].cnt_l, 1);
        out_ready[0] = 1'b1; tick(); out_ready[0] = 1'b0;
        check("t5 post-flush drained", g_dut[0].cnt_l, 0);

        // T4: DEPTH=3, values 1..20 with random handshakes.
        sent = 0; got = 0; cyc = 0;
        while (got < 20 && cyc < 500) begin
            in_valid[1]  = (sent < 20) && ($urandom_range(0, 3) != 0);
            in_data[1]   = 8'(sent + 1);
            out_ready[1] = ($urandom_range(0, 2) != 0);
            will_push = in_valid[1] && in_ready[1];
            will_pop  = out_valid[1] && out_ready[1];
            if (will_pop) rcv[got] = out_data[1];
            tick();
            if (will_push) sent++;
            if (will_pop) got++;
            cyc++;
        end
        in_valid[1] = 1'b0; out_ready[1] = 1'b0;
        check("t4 received count", 32'(got), 20);
        for (int i = 0; i < got; i++) begin
            check("t4 order", rcv[i], 32'(i + 1));
        end

        // T6: DEPTH=1 with continuous flow moves one entry every two cycles.
        pops = 0; val = 8'h30;
        in_valid[2] = 1'b1; out_ready[2] = 1'b1; in_data[2] = val;
        for (int k = 1; k <= 10; k++) begin
            will_push = in_ready[2];
            if (out_valid[2]) pops++;
            tick();
            if (will_push) begin
                val = val + 8'd1;
                in_data[2] = val;
            end
            check("t6 out_valid toggle", out_valid[2], 32'(k % 2));
        end
        in_valid[2] = 1'b0;
        check("t6 transfers", 32'(pops), 5);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
